wash_program_sequencer: RTL and testbench
=========================================

# wash_program_sequencer

Parametrised successor to the washing-machine program-select model. It keeps the program/water-level selection behaviour in the set state. It adds a run-time sequencer that counts down each enabled phase (wash, rinse, dry) from a tick divider, advances through phases, and reports per-phase and total remaining time plus a finish pulse. It sits between the top-level controller FSM (which drives `state`) and the display/actuator logic.

## Interface
Parameters:
- `TIME_W`, 5: width of a phase-time field, in time units.
- `LEVEL_MIN`, 3: water level/time restored on begin and on program change.
- `LEVEL_MAX`, 7: saturation ceiling for the water level; must be below 2^TIME_W.
- `WASH_T`, 10: fixed wash component; wash phase length = level + WASH_T.
- `RINSE_T`, 8: fixed rinse component; rinse phase length = level + RINSE_T.
- `DRY_T`, 5: dry phase length.
- `TICK_DIV`, 1000: clock cycles per time unit, ≥2.

Ports:
- `cp`, in, 1: clock, rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `state`, in, 3: controller state. 0 shutdown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish.
- `click`, in, 1: one-cycle select pulse.
- `water_btn`, in, 1: qualifies `click` as a water-level increment.
- `program`, out, 3: 0 WRD, 1 W, 2 WR, 3 R, 4 RD, 5 D, 6 USER.
- `level`, out, 3: current water level/time.
- `phase`, out, 2: 0 idle, 1 wash, 2 rinse, 3 dry.
- `remain`, out, TIME_W: remaining units of the current phase.
- `total_remain`, out, TIME_W+2: remaining units of the current phase plus all later enabled phases.
- `done`, out, 1: one-cycle pulse when the last phase expires.

## Operation
- Phase enables by program:
  - wash: 0, 1, 2, 6.
  - rinse: 0, 2, 3, 4, 6.
  - dry: 0, 4, 5, 6.
- Programs 0–5 use level `LEVEL_MIN`. Program 6 uses the stored `level`.
- Set state (2):
  - `click & !water_btn`: `program` increments, wrapping 6→0. `level` is restored to `LEVEL_MIN`.
  - `click & water_btn`: `program` is forced to 6. `level` increments, saturating at `LEVEL_MAX`.
- Begin (1) or shutdown (0):
  - `program` = 0 and `level` = `LEVEL_MIN`.
  - `phase` = 0, `remain` = 0, divider = 0.
  - `finished` flag is cleared.
- Run (3):
  - If `phase` = 0 and `finished` = 0, the first enabled phase is loaded with its length and the divider is cleared. This takes one cycle and no decrement occurs in that cycle.
  - Otherwise the divider counts. On the cycle it reaches `TICK_DIV`-1 it wraps to 0 and `remain` decrements.
  - When a decrement takes `remain` 1→0, the block loads the next enabled phase in the same cycle.
  - If no enabled phase follows: `phase` = 0, `finished` = 1, and `done` pulses.
- Pause (5), error (4), finish (6): divider, `remain` and `phase` all freeze. Resuming run continues from the frozen divider value.
- `program` and `level` change only in the set, begin and shutdown states. Clicks in any other state are ignored.
- All arithmetic is unsigned:
  - Phase length = `level` + constant, computed at width TIME_W with no overflow for legal parameters.
  - `total_remain` is computed at width TIME_W+2.

## Timing
- All outputs are registered and update on the rising edge of `cp`.
- Reset (`rst_n` = 0 sampled at an edge): `program` = 0, `level` = `LEVEL_MIN`, `phase` = 0, `remain` = 0, `total_remain` = 0, `done` = 0, divider = 0, `finished` = 0.
- Reset during run abandons the cycle immediately.
- Run entry latency: phase is loaded at the first edge with `state` = 3. First decrement occurs `TICK_DIV` edges later.
- `done` is high for exactly one cycle, on the same edge that `phase` returns to 0.
- Simultaneous events:
  - `click` and `water_btn` together: the water-increment action wins.
  - A tick edge and `state` ≠ 3 in the same cycle: no decrement.
- `total_remain` follows the same edge as `remain` and `phase`; it is not combinational.

## Configuration
- `WASH_SEQ_TOTAL_EN`
  - Defined: `total_remain` is computed as specified.
  - Undefined: `total_remain` is tied to 0, and the summing logic and its registers are removed. All other behaviour is unchanged.

## Test plan
Use `TICK_DIV` = 4 and default times unless noted.
- Program cycling: reset, state 2, 7 clicks with `water_btn` = 0. Expect `program` to step 1, 2, 3, 4, 5, 6, 0 and `level` to stay 3.
- Level saturation: state 2, 6 clicks with `water_btn` = 1. Expect `program` = 6 and `level` = 4, 5, 6, 7, 7, 7. A following plain click gives `program` = 0, `level` = 3.
- Full WRD run: program 0, state 3.
  - Phases run 1 (13 units), then 2 (11), then 3 (5).
  - `total_remain` = 29 at load.
  - `done` pulses at cycle 1 + 29·4 after run entry, and `phase` = 0 thereafter.
- Skip phases: program 5 in run. Expect only dry, `remain` = 5, `done` after 21 cycles.
- Pause freeze: in run with `remain` = 9 and divider = 2, hold state 5 for 50 cycles. Expect no change. Returning to state 3 gives a decrement 2 cycles later.
- Reset mid-run: assert `rst_n` = 0 for one edge during rinse. Expect all outputs at reset values and no `done`. Re-entering run reloads from the first phase.

Source files
------------

// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer
//   Program/water-level selection for the washing-machine controller plus a
//   run-time sequencer that counts down each enabled phase (wash, rinse, dry).
//   One time unit lasts TICK_DIV cycles of cp_i.
//
//   Optional feature macro: WASH_SEQ_TOTAL_EN
//     defined   - total_remain_o is the registered remaining time of the
//                 current phase plus all later enabled phases
//     undefined - total_remain_o is tied to 0 and its logic is absent
//
//   Ports
//     cp_i            clock, rising edge
//     rst_n_i         synchronous active-low reset
//     state_i[2:0]    controller state (0 shutdown, 1 begin, 2 set, 3 run,
//                     4 error, 5 pause, 6 finish)
//     click_i         one-cycle select pulse
//     water_btn_i     qualifies click_i as a water-level increment
//     program_o[2:0]  0 WRD, 1 W, 2 WR, 3 R, 4 RD, 5 D, 6 USER
//     level_o[2:0]    current water level/time
//     phase_o[1:0]    0 idle, 1 wash, 2 rinse, 3 dry
//     remain_o        remaining units of the current phase
//     total_remain_o  remaining units of current plus later enabled phases
//     done_o          one-cycle pulse when the last phase expires
//
//   Phase FSM
//     state    | meaning
//     ---------+----------------------------------------------------------
//     PH_IDLE  | no phase active (before run, or after the last phase)
//     PH_WASH  | wash running, remain = level + WASH_T at load
//     PH_RINSE | rinse running, remain = level + RINSE_T at load
//     PH_DRY   | dry running, remain = DRY_T at load
module wash_program_sequencer #(
   parameter int TIME_W    = 5,
   parameter int LEVEL_MIN = 3,
   parameter int LEVEL_MAX = 7,
   parameter int WASH_T    = 10,
   parameter int RINSE_T   = 8,
   parameter int DRY_T     = 5,
   parameter int TICK_DIV  = 1000
) (
   input  logic              cp_i,
   input  logic              rst_n_i,
   input  logic [2:0]        state_i,
   input  logic              click_i,
   input  logic              water_btn_i,
   output logic [2:0]        program_o,
   output logic [2:0]        level_o,
   output logic [1:0]        phase_o,
   output logic [TIME_W-1:0] remain_o,
   output logic [TIME_W+1:0] total_remain_o,
   output logic              done_o
);

   localparam int TOT_W = TIME_W + 2;
   localparam int DIV_W = $clog2(TICK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [2:0]       LVL_MIN  = 3'(LEVEL_MIN);
   localparam logic [2:0]       LVL_MAX  = 3'(LEVEL_MAX);
   localparam logic [2:0]       PROG_USER = 3'd6;

   localparam logic [2:0] ST_SHUTDOWN = 3'd0;
   localparam logic [2:0] ST_BEGIN    = 3'd1;
   localparam logic [2:0] ST_SET      = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_WASH  = 2'd1,
      PH_RINSE = 2'd2,
      PH_DRY   = 2'd3
   } phase_t;

   logic [2:0]        program_q, program_d;
   logic [2:0]        level_q, level_d;
   phase_t            phase_q, phase_d;
   logic [TIME_W-1:0] remain_q, remain_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              fin_q, fin_d;
   logic              done_q, done_d;

   logic [2:0]        level_eff;
   logic [2:0]        en;          // [0] wash, [1] rinse, [2] dry
   logic [TIME_W-1:0] len_wash, len_rinse, len_dry;
   phase_t            nxt;

   // First enabled phase strictly after cur; PH_IDLE when none remains.
   // Called with PH_IDLE it yields the first phase of the program.
   function automatic phase_t next_after(input phase_t cur, input logic [2:0] en_v);
      next_after = PH_IDLE;
      if (cur == PH_IDLE && en_v[0])
         next_after = PH_WASH;
      else if ((cur == PH_IDLE || cur == PH_WASH) && en_v[1])
         next_after = PH_RINSE;
      else if (cur != PH_DRY && en_v[2])
         next_after = PH_DRY;
   endfunction

   function automatic logic [TIME_W-1:0] phase_len(input phase_t ph,
                                                   input logic [TIME_W-1:0] lw,
                                                   input logic [TIME_W-1:0] lr,
                                                   input logic [TIME_W-1:0] ld);
      case (ph)
         PH_WASH:  phase_len = lw;
         PH_RINSE: phase_len = lr;
         PH_DRY:   phase_len = ld;
         default:  phase_len = '0;
      endcase
   endfunction

   always_comb begin
      case (program_q)
         3'd0, 3'd6: en = 3'b111;
         3'd1:       en = 3'b001;
         3'd2:       en = 3'b011;
         3'd3:       en = 3'b010;
         3'd4:       en = 3'b110;
         3'd5:       en = 3'b100;
         default:    en = 3'b000;
      endcase
   end

   // Only the user program honours the stored level.
   assign level_eff = (program_q == PROG_USER) ? level_q : LVL_MIN;
   assign len_wash  = TIME_W'(level_eff) + TIME_W'(WASH_T);
   assign len_rinse = TIME_W'(level_eff) + TIME_W'(RINSE_T);
   assign len_dry   = TIME_W'(DRY_T);
   assign nxt       = next_after(phase_q, en);

   always_comb begin
      program_d = program_q;
      level_d   = level_q;
      phase_d   = phase_q;
      remain_d  = remain_q;
      div_d     = div_q;
      fin_d     = fin_q;
      done_d    = 1'b0;
      case (state_i)
         ST_SHUTDOWN, ST_BEGIN: begin
            program_d = 3'd0;
            level_d   = LVL_MIN;
            phase_d   = PH_IDLE;
            remain_d  = '0;
            div_d     = '0;
            fin_d     = 1'b0;
         end
         ST_SET: begin
            if (click_i && water_btn_i) begin
               program_d = PROG_USER;
               level_d   = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 3'd1;
            end else if (click_i) begin
               program_d = (program_q >= PROG_USER) ? 3'd0 : program_q + 3'd1;
               level_d   = LVL_MIN;
            end
         end
         ST_RUN: begin
            if (phase_q == PH_IDLE) begin
               // Load cycle: no decrement, divider restarts.
               if (!fin_q) begin
                  phase_d  = nxt;
                  remain_d = phase_len(nxt, len_wash, len_rinse, len_dry);
                  div_d    = '0;
               end
            end else if (div_q == DIV_LAST) begin
               div_d = '0;
               if (remain_q == TIME_W'(1)) begin
                  // Expiry chains straight into the next phase on the same edge.
                  phase_d  = nxt;
                  remain_d = phase_len(nxt, len_wash, len_rinse, len_dry);
                  if (nxt == PH_IDLE) begin
                     fin_d  = 1'b1;
                     done_d = 1'b1;
                  end
               end else begin
                  remain_d = remain_q - TIME_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: ;
      endcase
   end

`ifdef WASH_SEQ_TOTAL_EN
   logic [TOT_W-1:0] total_q, total_d, later_sum;

   // Time still owed by enabled phases after the one being entered/held.
   always_comb begin
      later_sum = '0;
      case (phase_d)
         PH_WASH:  later_sum = (en[1] ? TOT_W'(len_rinse) : '0)
                             + (en[2] ? TOT_W'(len_dry) : '0);
         PH_RINSE: later_sum = en[2] ? TOT_W'(len_dry) : '0;
         default:  later_sum = '0;
      endcase
      total_d = TOT_W'(remain_d) + later_sum;
   end
`endif

   always_ff @(posedge cp_i) begin
      if (!rst_n_i) begin
         program_q <= 3'd0;
         level_q   <= LVL_MIN;
         phase_q   <= PH_IDLE;
         remain_q  <= '0;
         div_q     <= '0;
         fin_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef WASH_SEQ_TOTAL_EN
         total_q   <= '0;
`endif
      end else begin
         program_q <= program_d;
         level_q   <= level_d;
         phase_q   <= phase_d;
         remain_q  <= remain_d;
         div_q     <= div_d;
         fin_q     <= fin_d;
         done_q    <= done_d;
`ifdef WASH_SEQ_TOTAL_EN
         total_q   <= total_d;
`endif
      end
   end

   assign program_o = program_q;
   assign level_o   = level_q;
   assign phase_o   = phase_q;
   assign remain_o  = remain_q;
   assign done_o    = done_q;
`ifdef WASH_SEQ_TOTAL_EN
   assign total_remain_o = total_q;
`else
   assign total_remain_o = '0;
`endif

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Scoreboard bench for wash_program_sequencer with TICK_DIV = 4.
module tb_wash_program_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] state;
   logic       click;
   logic       water;
   logic [2:0] prog;
   logic [2:0] lvl;
   logic [1:0] ph;
   logic [4:0] rem;
   logic [6:0] tot;
   logic       done;

   wash_program_sequencer #(.TICK_DIV(4)) dut (
      .cp_i(clk), .rst_n_i(rst_n), .state_i(state), .click_i(click),
      .water_btn_i(water), .program_o(prog), .level_o(lvl), .phase_o(ph),
      .remain_o(rem), .total_remain_o(tot), .done_o(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      string      tag;
      logic [2:0] prog;
      logic [2:0] lvl;
      logic [1:0] ph;
      logic [4:0] rem;
      logic [6:0] tot;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   bit   end_req = 1'b0;

   // Hand-computed vectors
   logic [2:0] prog_tab[7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
   logic [2:0] lvl_tab[6]  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
   // WRD run: offset from run entry, phase, remain, total
   int wrd_off[10] = '{1, 4, 5, 52, 53, 96, 97, 116, 117, 120};
   int wrd_ph[10]  = '{1, 1, 1, 1, 2, 2, 3, 3, 0, 0};
   int wrd_rem[10] = '{13, 13, 12, 1, 11, 1, 5, 1, 0, 0};
   int wrd_tot[10] = '{29, 29, 28, 17, 16, 6, 5, 1, 0, 0};
   // Dry-only run
   int dry_off[4]  = '{1, 5, 20, 21};
   int dry_ph[4]   = '{3, 3, 3, 0};
   int dry_rem[4]  = '{5, 4, 1, 0};

   task automatic expect_at(input int at, input string tag, input int p, input int l,
                            input int phv, input int r, input int t);
      exp_t e;
      e.at   = at;
      e.tag  = tag;
      e.prog = 3'(p);
      e.lvl  = 3'(l);
      e.ph   = 2'(phv);
      e.rem  = 5'(r);
`ifdef WASH_SEQ_TOTAL_EN
      e.tot  = 7'(t);
`else
      e.tot  = 7'd0;
`endif
      exp_q.push_back(e);
   endtask

   // Monitor: pops expectations when their cycle arrives, and treats every
   // done pulse as a DUT output event matched against the done queue.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (mon_e.at != cyc) begin
            errors++;
            $display("FAIL %s: snapshot missed, due cycle %0d now %0d", mon_e.tag, mon_e.at, cyc);
         end else if (prog !== mon_e.prog || lvl !== mon_e.lvl || ph !== mon_e.ph ||
                      rem !== mon_e.rem || tot !== mon_e.tot) begin
            errors++;
            $display("FAIL %s @%0d: got prog=%0d lvl=%0d ph=%0d rem=%0d tot=%0d, expected prog=%0d lvl=%0d ph=%0d rem=%0d tot=%0d",
                     mon_e.tag, cyc, prog, lvl, ph, rem, tot,
                     mon_e.prog, mon_e.lvl, mon_e.ph, mon_e.rem, mon_e.tot);
         end
      end
      if (done === 1'b1) begin
         checks++;
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
         end else begin
            errors++;
            $display("FAIL done_pulse @%0d: got done=1, expected done=0", cyc);
         end
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
         checks++;
         errors++;
         $display("FAIL done_pulse: got no done, expected done=1 at cycle %0d", done_q[0]);
         void'(done_q.pop_front());
      end
      if (end_req) begin
         checks++;
         if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d snapshots and %0d done events pending, expected 0",
                     exp_q.size(), done_q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of run, expected summary before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0;
      state = 3'd0;
      click = 1'b0;
      water = 1'b0;
      @(negedge clk);
      expect_at(cyc + 1, "reset", 0, 3, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // program cycling
      state = 3'd2;
      for (int i = 0; i < 7; i++) begin
         click = 1'b1;
         expect_at(cyc + 1, "prog_cycle", prog_tab[i], 3, 0, 0, 0);
         @(negedge clk);
         click = 1'b0;
         @(negedge clk);
      end

      // level saturation, then plain click restores
      water = 1'b1;
      for (int i = 0; i < 6; i++) begin
         click = 1'b1;
         expect_at(cyc + 1, "level_sat", 6, lvl_tab[i], 0, 0, 0);
         @(negedge clk);
         click = 1'b0;
         @(negedge clk);
      end
      water = 1'b0;
      click = 1'b1;
      expect_at(cyc + 1, "level_restore", 0, 3, 0, 0, 0);
      @(negedge clk);
      click = 1'b0;

      // full WRD run
      state = 3'd3;
      base = cyc;
      for (int i = 0; i < 10; i++)
         expect_at(base + wrd_off[i], "wrd_run", 0, 3, wrd_ph[i], wrd_rem[i], wrd_tot[i]);
      done_q.push_back(base + 117);
      repeat (120) @(negedge clk);
      state = 3'd1;
      expect_at(cyc + 1, "begin_clear", 0, 3, 0, 0, 0);
      @(negedge clk);

      // dry-only program
      state = 3'd2;
      repeat (5) begin
         click = 1'b1;
         @(negedge clk);
         click = 1'b0;
         @(negedge clk);
      end
      expect_at(cyc + 1, "prog_d", 5, 3, 0, 0, 0);
      @(negedge clk);
      state = 3'd3;
      base = cyc;
      for (int i = 0; i < 4; i++)
         expect_at(base + dry_off[i], "dry_run", 5, 3, dry_ph[i], dry_rem[i], dry_rem[i]);
      done_q.push_back(base + 21);
      repeat (23) @(negedge clk);
      state = 3'd1;
      expect_at(cyc + 1, "begin_clear2", 0, 3, 0, 0, 0);
      @(negedge clk);

      // pause freeze at remain 9, divider 2; clicks ignored while paused
      state = 3'd3;
      base = cyc;
      expect_at(base + 19, "pre_pause", 0, 3, 1, 9, 25);
      repeat (19) @(negedge clk);
      state = 3'd5;
      click = 1'b1;
      water = 1'b1;
      base = cyc;
      expect_at(base + 1, "pause_hold", 0, 3, 1, 9, 25);
      expect_at(base + 50, "pause_end", 0, 3, 1, 9, 25);
      repeat (50) @(negedge clk);
      click = 1'b0;
      water = 1'b0;
      state = 3'd3;
      base = cyc;
      expect_at(base + 1, "resume", 0, 3, 1, 9, 25);
      expect_at(base + 2, "resume_dec", 0, 3, 1, 8, 24);
      repeat (2) @(negedge clk);

      // run into rinse, then reset mid-run
      base = cyc;
      expect_at(base + 40, "in_rinse", 0, 3, 2, 9, 14);
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      expect_at(cyc + 1, "reset_mid", 0, 3, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      expect_at(base + 1, "reload", 0, 3, 1, 13, 29);
      expect_at(base + 5, "reload_dec", 0, 3, 1, 12, 28);
      repeat (5) @(negedge clk);
      state = 3'd1;
      repeat (3) @(negedge clk);
      end_req = 1'b1;
      repeat (2) @(negedge clk);
   end

endmodule
